fix_hpf_mc: RTL and testbench

//  Multi-channel first-order fixed-point high-pass (DC-block) filter with a built-in corner table.
//  Per channel: y[n] = sat((B*(x[n]-x[n-1]) + P*y[n-1] + 2^(FRAC-1)) >>> FRAC).
//  NCH channels are time-multiplexed through one datapath, with valid/ready on both sides.

---
 rtl/fix_hpf_pkg.sv | 48 ++++
 rtl/fix_hpf_coef_rom.sv | 34 +++
 rtl/fix_hpf_mc.sv | 148 ++++++++++++++
 tb/tb_fix_hpf_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fix_hpf_pkg.sv
// Shared constants, corner encodings, state encoding and the output saturator
// for the multi-channel DC-block filter.
package fix_hpf_pkg;

    localparam int DW   = 16;             // sample width, signed
    localparam int CW   = 16;             // coefficient width, unsigned
    localparam int FRAC = 10;             // coefficient fractional bits
    localparam int SW   = DW + CW + 2;    // accumulator width

    localparam logic signed [SW-1:0] RND     = SW'(2 ** (FRAC - 1));
    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -(SW'(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        CORNER_BYPASS = 2'd0,
        CORNER_008    = 2'd1,
        CORNER_002    = 2'd2,
        CORNER_00025  = 2'd3
    } corner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // (B, P) pairs in Q.FRAC; B = (1+P)/2 for a first-order DC blocker.
    localparam logic [CW-1:0] B_008   = CW'(732);
    localparam logic [CW-1:0] P_008   = CW'(441);
    localparam logic [CW-1:0] B_002   = CW'(931);
    localparam logic [CW-1:0] P_002   = CW'(838);
    localparam logic [CW-1:0] B_00025 = CW'(1011);
    localparam logic [CW-1:0] P_00025 = CW'(998);

    // Clamp a shifted accumulator value to the signed sample range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
        logic signed [DW-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DW-1:0];
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fix_hpf_coef_rom.sv
// Corner selector to filter coefficients; purely combinational, the top
// registers the result when a frame starts.
module fix_hpf_coef_rom
    import fix_hpf_pkg::*;
(
    input  logic [1:0]    sel_i,
    output logic          bypass_o,
    output logic [CW-1:0] b_o,
    output logic [CW-1:0] p_o
);

    // Table lookup; bypass carries zero coefficients since they are unused.
    always_comb begin
        bypass_o = 1'b0;
        b_o      = '0;
        p_o      = '0;
        case (corner_e'(sel_i))
            CORNER_008: begin
                b_o = B_008;
                p_o = P_008;
            end
            CORNER_002: begin
                b_o = B_002;
                p_o = P_002;
            end
            CORNER_00025: begin
                b_o = B_00025;
                p_o = P_00025;
            end
            default: bypass_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fix_hpf_mc.sv
// Time-multiplexed first-order DC-block filter for NCH channels.
//   state   | meaning
//   IDLE    | in_ready high, waiting for a sample
//   CALC    | compute filter output, update history of the sample's channel
//   OUT     | present result; out_valid rises one cycle after entry, held until out_ready
module fix_hpf_mc
    import fix_hpf_pkg::*;
#(
    parameter  int NCH = 2,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           sel_corner,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic [DW-1:0]        out_data
);

    state_e state_q, state_d;

    logic signed [DW-1:0] x_q;
    logic [CHW-1:0]       ch_q;
    logic                 byp_q;
    logic [CW-1:0]        b_q, p_q;
    logic signed [DW-1:0] x1_q [NCH];
    logic signed [DW-1:0] y1_q [NCH];
    logic [DW-1:0]        out_data_q;
    logic [CHW-1:0]       out_ch_q;
    logic                 out_valid_q;

    logic                 rom_byp;
    logic [CW-1:0]        rom_b, rom_p;
    logic                 accept;
    logic                 ch_ok;
    logic [CHW-1:0]       ch_idx;
    logic signed [DW:0]   diff;
    logic signed [SW-1:0] prod_b, prod_p, acc, shifted;
    logic signed [DW-1:0] y_calc;

    fix_hpf_coef_rom u_rom (
        .sel_i    (sel_corner),
        .bypass_o (rom_byp),
        .b_o      (rom_b),
        .p_o      (rom_p)
    );

    assign accept    = in_valid & in_ready;
    assign ch_ok     = (int'(ch_q) < NCH);
    assign ch_idx    = ch_ok ? ch_q : '0;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

    // Filter datapath for the captured sample against its channel history.
    always_comb begin
        diff    = {x_q[DW-1], x_q} - {x1_q[ch_idx][DW-1], x1_q[ch_idx]};
        prod_b  = SW'(diff) * $signed(SW'(b_q));
        prod_p  = SW'(y1_q[ch_idx]) * $signed(SW'(p_q));
        acc     = prod_b + prod_p + RND;
        shifted = acc >>> FRAC;
        y_calc  = byp_q ? x_q : sat_dw(shifted);
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_CALC;
            end
            ST_CALC: state_d = ch_ok ? ST_OUT : ST_IDLE;
            ST_OUT:  if (out_valid_q && out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Sample capture and per-frame corner latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            ch_q  <= '0;
            byp_q <= 1'b1;
            b_q   <= '0;
            p_q   <= '0;
        end else if (accept) begin
            x_q  <= in_data;
            ch_q <= in_ch;
            if (in_ch == '0) begin
                byp_q <= rom_byp;
                b_q   <= rom_b;
                p_q   <= rom_p;
            end
        end
    end

    // Channel history; a clear overrides an update landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                x1_q[i] <= '0;
                y1_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NCH; i++) begin
                x1_q[i] <= '0;
                y1_q[i] <= '0;
            end
        end else if (state_q == ST_CALC && ch_ok) begin
            x1_q[ch_idx] <= x_q;
            y1_q[ch_idx] <= y_calc;
        end
    end

    // Output register; valid asserts on the second OUT cycle and drops on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q == ST_CALC && ch_ok) begin
                out_data_q <= y_calc;
                out_ch_q   <= ch_q;
            end
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end else if (state_q == ST_OUT) begin
                out_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fix_hpf_mc.sv
// Directed bench for the multi-channel DC-block filter.
module tb_fix_hpf_mc;
    import fix_hpf_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       sel_corner;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [0:0]       in_ch;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [0:0]       out_ch;
    logic [DW-1:0]    out_data;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int ch;
        int sel;
        int x;
        int exp_y;
    } vec_t;

    always #5 clk = ~clk;

    fix_hpf_mc #(.NCH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_corner (sel_corner),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_data   (out_data)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One sample through the block; optionally hold out_ready low or pulse clear in CALC.
    task automatic send(input int ch, input int sel, input int x, input int hold,
                        input bit clr_calc, output int y, output int och, output int lat);
        bit ok;
        in_ch      = ch[0:0];
        sel_corner = sel[1:0];
        in_data    = x[DW-1:0];
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = clr_calc;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            clear = 1'b0;
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", 0, 1);
        y   = int'($signed(out_data));
        och = int'(out_ch);
        for (int k = 0; k < hold; k++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'($signed(out_data)), y);
            chk("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic run_table(input vec_t tv[], input string nm);
        int y, och, lat;
        foreach (tv[i]) begin
            send(tv[i].ch, tv[i].sel, tv[i].x, 0, 1'b0, y, och, lat);
            chk({nm, "_y"}, y, tv[i].exp_y);
            chk({nm, "_ch"}, och, tv[i].ch);
            chk({nm, "_lat"}, lat, 2);
        end
    endtask

    initial begin
        vec_t dc_tbl[]  = '{
            '{0, 1, 1000, 715}, '{1, 1, 0, 0}, '{0, 1, 1000, 308}, '{1, 1, 0, 0},
            '{0, 1, 1000, 133}, '{1, 1, 0, 0}, '{0, 1, 1000, 57}
        };
        vec_t sat_tbl[] = '{
            '{0, 3, -32768, -32352}, '{0, 3, 32767, 32767}, '{0, 3, -32768, -32768}
        };
        vec_t lat_tbl[] = '{
            '{0, 1, 1000, 715}, '{1, 3, 1000, 715}, '{0, 3, 1000, 697}
        };
        int y, och, lat, x;

        rst        = 1'b1;
        sel_corner = 2'd0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_ch      = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_table(dc_tbl, "dc");
        pulse_clear();
        run_table(sat_tbl, "sat");
        pulse_clear();

        for (int i = 0; i < 6; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            send(i % 2, 0, x, 0, 1'b0, y, och, lat);
            chk("byp_y", y, x);
            chk("byp_ch", och, i % 2);
            chk("byp_lat", lat, 2);
        end

        send(1, 0, -77, 5, 1'b0, y, och, lat);
        chk("bp_y", y, -77);
        chk("bp_post_in_ready", int'(in_ready), 1);
        chk("bp_post_valid", int'(out_valid), 0);
        pulse_clear();

        run_table(lat_tbl, "corner");

        send(0, 1, 1000, 0, 1'b1, y, och, lat);
        chk("clr_calc_y", y, 300);
        send(0, 1, 1000, 0, 1'b0, y, och, lat);
        chk("clr_after_y", y, 715);

        in_ch      = 1'b0;
        sel_corner = 2'd1;
        in_data    = DW'(1000);
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_data", int'(out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(0, 1, 1000, 0, 1'b0, y, och, lat);
        chk("arst_hist_y", y, 715);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
